// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver with leading-zero blanking.
// Inputs are shadowed once per full scan so that a frame never mixes old and new digits.
module seg_display_mux #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned OnCycles = REFRESH_DIV - BLANK_CYCLES;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     sh_dig_q, sh_dig_d;
    logic [3:0]      sh_dp_q, sh_dp_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic            slot_end;
    logic [3:0]      cur_dig;
    logic [3:0]      nz;
    logic [3:0]      blank;
    logic            active;

    function automatic logic [6:0] decode(input logic [3:0] d);
        unique case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        slot_end = (cnt_q == CntMax);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? idx_q + 2'd1 : idx_q;
        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        if (slot_end && idx_q == 2'd3) begin
            sh_dig_d = digits;
            sh_dp_d  = dp_in;
        end

        // Non-BCD nibbles count as nonzero, so they stop the blanking chain.
        for (int i = 0; i < 4; i++) begin
            nz[i] = (sh_dig_q[i*4 +: 4] != 4'd0);
        end
        blank[3] = LZ_BLANK && !nz[3];
        blank[2] = LZ_BLANK && !nz[3] && !nz[2];
        blank[1] = LZ_BLANK && !nz[3] && !nz[2] && !nz[1];
        blank[0] = 1'b0;

        cur_dig = sh_dig_q[{idx_q, 2'b00} +: 4];
        active  = enable && !blank[idx_q] && ({1'b0, cnt_q} < (CntW + 1)'(OnCycles));

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (active) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(cur_dig);
            dp_d  = ~sh_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            sh_dig_q <= 16'h0000;
            sh_dp_q  <= 4'h0;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            an_q     <= 4'b1111;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_dig_q <= sh_dig_d;
            sh_dp_q  <= sh_dp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux with REFRESH_DIV=8, BLANK_CYCLES=2, LZ_BLANK=1.
module tb_seg_display_mux;

    logic        clk;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [11:0] Dark = {4'b1111, 7'b1111111, 1'b1};

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SX = 7'b1111111;

    seg_display_mux #(
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .digits (digits),
        .dp_in  (dp_in),
        .enable (enable),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc, input logic [11:0] exp);
        logic [11:0] got;
        got = {an, seg, dp};
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                   tag, cyc, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Steps n cycles from slot0/cnt0, checking each output cycle against the slot table.
    // segs = {slot3, slot2, slot1, slot0}; act = which slots are lit; dpe = expected dp.
    task automatic check_scan(input string tag, input logic [27:0] segs, input logic [3:0] act,
                              input logic [3:0] dpe, input int n, input int chg_at,
                              input logic [15:0] chg_dig, input int en_off_at,
                              input int en_on_at);
        logic [27:0] sv;
        logic [3:0]  onehot;
        logic [11:0] exp;
        logic        en_now;
        int          s;
        int          c;
        sv = segs;
        for (int i = 0; i < n; i++) begin
            en_now = enable;
            step();
            s      = i / 8;
            c      = i % 8;
            onehot = 4'b0001 << s;
            if (act[s] && en_now && c < 6) exp = {~onehot, sv[s*7 +: 7], dpe[s]};
            else exp = Dark;
            check(tag, i, exp);
            if (i == chg_at) digits = chg_dig;
            if (i == en_off_at) enable = 1'b0;
            if (i == en_on_at) enable = 1'b1;
        end
    endtask

    initial begin
        rst    = 1'b1;
        digits = 16'h1234;
        dp_in  = 4'b0010;
        enable = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", i, Dark);
        end
        rst = 1'b0;

        check_scan("first_scan", {SX, SX, SX, S0}, 4'b0001, 4'b1101, 32, -1, 16'h0, -1, -1);
        check_scan("scan_1234", {S1, S2, S3, S4}, 4'b1111, 4'b1101, 32, 10, 16'h5678, -1, -1);
        check_scan("scan_5678", {S5, S6, S7, S8}, 4'b1111, 4'b1101, 32, 0, 16'h0405, -1, -1);
        check_scan("lz_0405", {SX, S4, S0, S5}, 4'b0111, 4'b1101, 32, 0, 16'h0000, -1, -1);
        check_scan("lz_0000", {SX, SX, SX, S0}, 4'b0001, 4'b1101, 32, 0, 16'h00A7, -1, -1);
        check_scan("nonbcd_00a7", {SX, SX, SX, S7}, 4'b0011, 4'b1101, 32, 0, 16'h1234, -1, -1);
        check_scan("enable_gap", {S1, S2, S3, S4}, 4'b1111, 4'b1101, 32, -1, 16'h0, 2, 12);

        check_scan("pre_reset", {S1, S2, S3, S4}, 4'b1111, 4'b1101, 18, -1, 16'h0, -1, -1);
        rst = 1'b1;
        step();
        check("mid_reset", 0, Dark);
        rst = 1'b0;
        check_scan("after_reset", {SX, SX, SX, S0}, 4'b0001, 4'b1101, 32, -1, 16'h0, -1, -1);
        check_scan("reload", {S1, S2, S3, S4}, 4'b1111, 4'b1101, 32, -1, 16'h0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
